// File: rtl/branch_sequencer_pkg.sv
// Shared definitions for the conditional-branch sequencer: states, opcodes,
// condition-select encodings and IR field positions.
package branch_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      T3   = 3'd1,
      T4   = 3'd2,
      T5   = 3'd3,
      T6   = 3'd4
   } state_e;

   localparam logic [4:0] OP_LD  = 5'b00000;
   localparam logic [4:0] OP_ST  = 5'b00010;
   localparam logic [4:0] OP_ADD = 5'b00011;
   localparam logic [4:0] OP_BR  = 5'b10010;
   localparam logic [4:0] OP_JR  = 5'b10100;

   localparam logic [1:0] C2_ZR = 2'b00;
   localparam logic [1:0] C2_NZ = 2'b01;
   localparam logic [1:0] C2_PL = 2'b10;
   localparam logic [1:0] C2_MI = 2'b11;

   localparam int unsigned OP_HI = 31;
   localparam int unsigned OP_LO = 27;
   localparam int unsigned RA_HI = 26;
   localparam int unsigned RA_LO = 23;
   localparam int unsigned C2_HI = 20;
   localparam int unsigned C2_LO = 19;

   function automatic logic [4:0] opcode_of(input logic [31:0] ir);
      return ir[OP_HI:OP_LO];
   endfunction

endpackage

// File: rtl/branch_perf_counter.sv
// Wrapping debug counters for completed and taken branch sequences.
module branch_perf_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             br_inc,
   input  logic             tk_inc,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] taken_count
);

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         branch_count <= '0;
         taken_count  <= '0;
      end else begin
         if (br_inc) branch_count <= branch_count + CNT_W'(1);
         if (tk_inc) taken_count  <= taken_count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/branch_sequencer.sv
// T3-T6 control sequencer for brzr/brnz/brpl/brmi on the shared-bus datapath.
// Strobes decode from state; only load strobes and completion pulses see stall.
module branch_sequencer
   import branch_sequencer_pkg::*;
#(
   parameter logic [4:0]   BR_OPCODE = OP_BR,
   parameter int unsigned  CNT_W     = 16
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             start,
   input  logic [31:0]      ir,
   input  logic             stall,
   input  logic             con_flag,
   output logic             busy,
   output logic             done,
   output logic             illegal,
   output logic [1:0]       c2_bits,
   output logic             gra,
   output logic             r_out,
   output logic             con_in,
   output logic             pc_out,
   output logic             y_in,
   output logic             c_out,
   output logic             alu_add,
   output logic             z_in,
   output logic             zlow_out,
   output logic             pc_in,
   output logic             taken,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] taken_count
);

   state_e     state_q, state_d;
   logic [1:0] c2_d;
   logic       illegal_d;
   logic       ir_unused;

   // Only opcode and condition select matter here; Ra is consumed by the register file.
   assign ir_unused = ^{ir[RA_HI:21], ir[18:0]};

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q <= IDLE;
         c2_bits <= 2'b00;
         illegal <= 1'b0;
      end else begin
         state_q <= state_d;
         c2_bits <= c2_d;
         illegal <= illegal_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      c2_d      = c2_bits;
      illegal_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (opcode_of(ir) == BR_OPCODE) begin
                  state_d = T3;
                  c2_d    = ir[C2_HI:C2_LO];
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end
         T3:      if (!stall) state_d = T4;
         T4:      if (!stall) state_d = T5;
         T5:      if (!stall) state_d = T6;
         T6:      if (!stall) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus drivers hold through a stall; loads and pulses wait for release.
   always_comb begin
      busy     = (state_q != IDLE);
      gra      = (state_q == T3);
      r_out    = (state_q == T3);
      con_in   = (state_q == T3) && !stall;
      pc_out   = (state_q == T4);
      y_in     = (state_q == T4) && !stall;
      c_out    = (state_q == T5);
      alu_add  = (state_q == T5);
      z_in     = (state_q == T5) && !stall;
      zlow_out = (state_q == T6) && con_flag;
      pc_in    = (state_q == T6) && con_flag && !stall;
      taken    = (state_q == T6) && con_flag && !stall;
      done     = (state_q == T6) && !stall;
   end

   branch_perf_counter #(
      .CNT_W (CNT_W)
   ) u_perf (
      .clk          (clk),
      .clear_n      (clear_n),
      .br_inc       (done),
      .tk_inc       (taken),
      .branch_count (branch_count),
      .taken_count  (taken_count)
   );

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer with narrow counters so wrap is reachable.
module tb_branch_sequencer;

   localparam int unsigned CW = 2;

   logic          clk = 1'b0;
   logic          clear_n;
   logic          start;
   logic [31:0]   ir;
   logic          stall;
   logic          con_flag;
   logic          busy, done, illegal;
   logic [1:0]    c2_bits;
   logic          gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in;
   logic          zlow_out, pc_in, taken;
   logic [CW-1:0] branch_count, taken_count;
   logic [13:0]   sig;

   int checks = 0;
   int errors = 0;
   int exp_br = 0;
   int exp_tk = 0;

   localparam logic [13:0] S_IDLE = 14'b00000000000000;
   localparam logic [13:0] S_ILL  = 14'b00000000000001;
   localparam logic [13:0] S_T3   = 14'b11100000000010;
   localparam logic [13:0] S_T3S  = 14'b11000000000010;
   localparam logic [13:0] S_T4   = 14'b00011000000010;
   localparam logic [13:0] S_T4S  = 14'b00010000000010;
   localparam logic [13:0] S_T5   = 14'b00000111000010;
   localparam logic [13:0] S_T6T  = 14'b00000000111110;
   localparam logic [13:0] S_T6N  = 14'b00000000000110;

   always #5 clk = ~clk;

   assign sig = {gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in,
                 zlow_out, pc_in, taken, done, busy, illegal};

   branch_sequencer #(
      .CNT_W (CW)
   ) dut (
      .clk          (clk),
      .clear_n      (clear_n),
      .start        (start),
      .ir           (ir),
      .stall        (stall),
      .con_flag     (con_flag),
      .busy         (busy),
      .done         (done),
      .illegal      (illegal),
      .c2_bits      (c2_bits),
      .gra          (gra),
      .r_out        (r_out),
      .con_in       (con_in),
      .pc_out       (pc_out),
      .y_in         (y_in),
      .c_out        (c_out),
      .alu_add      (alu_add),
      .z_in         (z_in),
      .zlow_out     (zlow_out),
      .pc_in        (pc_in),
      .taken        (taken),
      .branch_count (branch_count),
      .taken_count  (taken_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_counts(input string tag);
      chk({tag, ".branch_count"}, 32'(branch_count), 32'(exp_br % 4));
      chk({tag, ".taken_count"},  32'(taken_count),  32'(exp_tk % 4));
   endtask

   // One full branch from IDLE; optional T4 stall and an ignored start while busy.
   task automatic run_branch(input string tag, input logic [31:0] ir_v, input logic cf,
                             input int stall_t4, input bit poke);
      logic [1:0] c2_exp;
      c2_exp = ir_v[20:19];
      @(negedge clk); start = 1'b1; ir = ir_v;
      @(negedge clk); start = 1'b0; ir = 32'h0; #1;
      chk({tag, ".t3"}, 32'(sig), 32'(S_T3));
      chk({tag, ".c2"}, 32'(c2_bits), 32'(c2_exp));
      @(negedge clk);
      if (poke) begin
         start = 1'b1; ir = 32'h9018_0000;
      end
      if (stall_t4 > 0) begin
         stall = 1'b1; #1;
         chk({tag, ".t4_stall"}, 32'(sig), 32'(S_T4S));
         for (int i = 1; i < stall_t4; i++) begin
            @(negedge clk); #1;
            chk({tag, ".t4_stall"}, 32'(sig), 32'(S_T4S));
         end
         @(negedge clk); stall = 1'b0;
      end
      #1;
      chk({tag, ".t4"}, 32'(sig), 32'(S_T4));
      @(negedge clk); start = 1'b0; ir = 32'h0; #1;
      chk({tag, ".t5"}, 32'(sig), 32'(S_T5));
      if (poke) chk({tag, ".c2_kept"}, 32'(c2_bits), 32'(c2_exp));
      @(negedge clk); con_flag = cf; #1;
      chk({tag, ".t6"}, 32'(sig), 32'(cf ? S_T6T : S_T6N));
      exp_br++;
      if (cf) exp_tk++;
      @(negedge clk); con_flag = 1'b0; #1;
      chk({tag, ".idle"}, 32'(sig), 32'(S_IDLE));
      chk_counts(tag);
   endtask

   initial begin
      clear_n  = 1'b0;
      start    = 1'b0;
      ir       = 32'h0;
      stall    = 1'b0;
      con_flag = 1'b0;

      @(negedge clk); #1;
      chk("reset.sig", 32'(sig), 32'(S_IDLE));
      chk("reset.c2", 32'(c2_bits), 32'd0);
      chk_counts("reset");
      clear_n = 1'b1;

      run_branch("brzr_taken", 32'h9000_0000, 1'b1, 0, 1'b0);
      run_branch("brnz_not_taken", 32'h9008_0000, 1'b0, 0, 1'b1);
      run_branch("brpl_stall", 32'h9010_0000, 1'b1, 3, 1'b0);

      // Non-branch opcode, with stall high to show IDLE ignores it.
      @(negedge clk); start = 1'b1; ir = 32'h1800_0000; stall = 1'b1; #1;
      chk("illegal.pre", 32'(sig), 32'(S_IDLE));
      @(negedge clk); start = 1'b0; ir = 32'h0; stall = 1'b0; #1;
      chk("illegal.pulse", 32'(sig), 32'(S_ILL));
      @(negedge clk); #1;
      chk("illegal.clear", 32'(sig), 32'(S_IDLE));

      // Reset during T5 aborts before any PC load.
      @(negedge clk); start = 1'b1; ir = 32'h9018_0000; con_flag = 1'b1;
      @(negedge clk); start = 1'b0; ir = 32'h0; #1;
      chk("abort.c2", 32'(c2_bits), 32'(2'b11));
      @(negedge clk);
      @(negedge clk); #1;
      chk("abort.t5", 32'(sig), 32'(S_T5));
      clear_n = 1'b0; #1;
      exp_br = 0; exp_tk = 0;
      chk("abort.sig", 32'(sig), 32'(S_IDLE));
      chk("abort.c2_clr", 32'(c2_bits), 32'd0);
      chk_counts("abort");
      @(negedge clk); #1;
      chk("abort.held", 32'(sig), 32'(S_IDLE));
      clear_n = 1'b1; con_flag = 1'b0;
      @(negedge clk); #1;
      chk("abort.after", 32'(sig), 32'(S_IDLE));

      for (int n = 0; n < 5; n++) run_branch("wrap", 32'h9000_0000, 1'b1, 0, 1'b0);
      chk("wrap.branch_final", 32'(branch_count), 32'd1);
      chk("wrap.taken_final", 32'(taken_count), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Multi-cycle control FSM that runs conditional-branch instructions (brzr, brnz, brpl, brmi) on the shared-bus datapath.
- Drives the bus-source, register-load and CON flip-flop strobes in a fixed T3–T6 order, and samples the CON flag to decide whether PC takes the branch target.
- Sits between the main control unit, which hands over a branch instruction after fetch (T0–T2), and the datapath plus the CON flag logic.
- Keeps wrapping branch and taken counters for debug.

Parameters:
BR_OPCODE, 5'b10010, IR[31:27] value identifying a conditional branch
CNT_W, 16, width of the branch and taken performance counters

Ports:
clk  in  1  system clock, rising edge
clear_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request: ir is valid and a branch may begin
ir  in  32  instruction register contents
stall  in  1  freeze sequencing (memory or bus not ready)
con_flag  in  1  CON flag output from the condition flip-flop
busy  out  1  sequence in progress
done  out  1  one-cycle pulse when the sequence completes
illegal  out  1  one-cycle pulse: start seen with a non-branch opcode
c2_bits  out  2  latched IR[20:19], condition select for the CON logic
gra  out  1  select the Ra field for register-file output
r_out  out  1  register file drives the bus
con_in  out  1  CON flip-flop capture strobe
pc_out  out  1  PC drives the bus
y_in  out  1  load Y
c_out  out  1  sign-extended C field drives the bus
alu_add  out  1  ALU operation is ADD
z_in  out  1  load Z
zlow_out  out  1  Z low word drives the bus
pc_in  out  1  load PC from the bus
taken  out  1  one-cycle pulse in T6 when the branch is taken
branch_count  out  CNT_W  number of completed branch sequences
taken_count  out  CNT_W  number of taken branches

Behaviour:
- Reset (clear_n low, asynchronous):
  - state goes to IDLE.
  - All strobes, busy, done, illegal and taken go to 0.
  - c2_bits goes to 2'b00; both counters go to 0.
  - Reset asserted mid-sequence aborts immediately. PC is not loaded.
- States: IDLE, T3, T4, T5, T6. One-hot or binary encoding is allowed. All outputs are registered or decoded from state only; no combinational path from inputs to strobes except the stall gating below.
- IDLE:
  - start=1 and ir[31:27]==BR_OPCODE: latch c2_bits<=ir[20:19], go to T3, busy=1 from the next cycle.
  - start=1 with any other opcode: illegal=1 for the next cycle, stay in IDLE.
- Strobes by state:
  - T3: gra, r_out, con_in.
  - T4: pc_out, y_in.
  - T5: c_out, alu_add, z_in.
  - T6: if con_flag=1, then zlow_out, pc_in and taken. If con_flag=0, no strobes.
- T6 transition: go to IDLE. done=1 for that single T6 cycle, busy stays 1 during T6 and drops to 0 in IDLE.
- Latency: exactly 4 cycles from the first T3 cycle to the done pulse, with no stalls.
- con_flag is sampled only in T6. It is at least two cycles after the con_in edge, so CON flip-flop settle time is met.
- stall=1 in any T-state:
  - State holds.
  - Bus-drive strobes (gra, r_out, pc_out, c_out, alu_add, zlow_out) stay asserted.
  - Load strobes (con_in, y_in, z_in, pc_in) are forced to 0.
  - done and taken are suppressed.
  - On release, the state's full strobe set re-asserts for one cycle and then advances. A second con_in edge in T3 recaptures the same bus value.
- stall=1 in IDLE has no effect; start is still accepted.
- start while busy is ignored: no latch, no illegal.
- Counters:
  - branch_count increments in the T6 cycle that advances.
  - taken_count increments in the same cycle when con_flag=1.
  - Both wrap modulo 2^CNT_W; no saturation.
- Exactly one state is active at any time. An unreachable state encoding recovers to IDLE on the next clock.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, T3, T4, T5, T6);
  - BR_OPCODE and the other opcode constants;
  - C2 encodings: ZR=00, NZ=01, PL=10, MI=11;
  - IR field positions (opcode 31:27, Ra 26:23, C2 20:19).
- One sub-module: branch_perf_counter (the two wrapping CNT_W counters with increment enables).

Test Plan:
- brzr taken: ir=0x9000_0000|C2=00, con_flag=1 at T6 -> sequence T3..T6, pc_in=1 and zlow_out=1 in T6, taken=1, done at cycle 4, taken_count=1, branch_count=1.
- brnz not taken: C2=01, con_flag=0 -> c2_bits=01, no pc_in/zlow_out in T6, done=1, taken=0, branch_count=1, taken_count=0.
- Stall in T4 for 3 cycles -> pc_out held high, y_in=0 during stall, y_in=1 for one cycle on release, done at cycle 7.
- Non-branch start: ir[31:27]=5'b00011 -> illegal pulse next cycle, busy stays 0, no strobes.
- Reset mid-sequence: clear_n low during T5 -> all outputs 0 asynchronously, state IDLE, counters 0, no pc_in ever asserted.
- Counter wrap with CNT_W=2: five taken branches -> taken_count=1, branch_count=1; start during busy is ignored.
